// File: rtl/eep_i2c_pkg.sv
// rtl/eep_i2c_pkg.sv - shared types and constants for the EEPROM I2C master
package eep_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WR_BIT,
        ST_RD_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CMD_START = 0;
    localparam int CMD_WRITE = 1;
    localparam int CMD_READ  = 2;
    localparam int CMD_STOP  = 3;
    localparam int CMD_NACK  = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_NACK = 1;
    localparam int STAT_HELD = 2;

endpackage

// File: rtl/eep_i2c_tick.sv
// rtl/eep_i2c_tick.sv - quarter-SCL-period divider with synchronous restart
module eep_i2c_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eep_i2c_master.sv
// rtl/eep_i2c_master.sv - byte-level I2C master with a DATA/CMD/STATUS register slave
module eep_i2c_master
    import eep_i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    inout  wire         scl,
    inout  wire         sda
);

    state_t      state, next_state;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_byte, tx_shift, rx_shift, rx_byte;
    logic        op_write, op_read, op_stop, op_nack;
    logic        nack, nack_pend, bus_held;
    logic [1:0]  sda_sync, scl_sync;
    logic        tick, busy, launch, last_q;
    logic        scl_low, sda_low;

    assign busy   = (state != ST_IDLE);
    assign launch = chipselect && !write_n && (address == ADDR_CMD) && !busy
                    && (|writedata[CMD_STOP:CMD_START]);
    assign last_q = tick && (q == 2'd3);

    eep_i2c_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (launch),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    if (writedata[CMD_START])      next_state = ST_START;
                    else if (writedata[CMD_WRITE]) next_state = ST_WR_BIT;
                    else if (writedata[CMD_READ])  next_state = ST_RD_BIT;
                    else                           next_state = ST_STOP;
                end
            end
            ST_START: begin
                if (last_q) begin
                    if (op_write)     next_state = ST_WR_BIT;
                    else if (op_read) next_state = ST_RD_BIT;
                    else if (op_stop) next_state = ST_STOP;
                    else              next_state = ST_IDLE;
                end
            end
            ST_WR_BIT, ST_RD_BIT: if (last_q && bit_cnt == 3'd7) next_state = ST_ACK;
            ST_ACK:  if (last_q) next_state = op_stop ? ST_STOP : ST_IDLE;
            ST_STOP: if (last_q) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // SCL stays low between commands while the bus is held so the slave cannot see a spurious edge
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state)
            ST_IDLE:   scl_low = bus_held;
            ST_START: begin
                scl_low = (q == 2'd3);
                sda_low = q[1];
            end
            ST_WR_BIT: begin
                scl_low = (q == 2'd0) || (q == 2'd3);
                sda_low = !tx_shift[7];
            end
            ST_RD_BIT: scl_low = (q == 2'd0) || (q == 2'd3);
            ST_ACK: begin
                scl_low = (q == 2'd0) || (q == 2'd3);
                sda_low = op_read && !op_nack;
            end
            ST_STOP: begin
                scl_low = (q == 2'd0);
                sda_low = (q != 2'd3);
            end
            default: ;
        endcase
    end

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q         <= '0;
            bit_cnt   <= '0;
            tx_byte   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            op_write  <= 1'b0;
            op_read   <= 1'b0;
            op_stop   <= 1'b0;
            op_nack   <= 1'b0;
            nack      <= 1'b0;
            nack_pend <= 1'b0;
            bus_held  <= 1'b0;
            sda_sync  <= 2'b11;
            scl_sync  <= 2'b11;
            readdata  <= '0;
        end else begin
            sda_sync <= {sda_sync[0], sda};
            scl_sync <= {scl_sync[0], scl};

            if (chipselect && !write_n && !busy && address == ADDR_DATA)
                tx_byte <= writedata[7:0];

            if (launch) begin
                q        <= '0;
                bit_cnt  <= '0;
                tx_shift <= tx_byte;
                op_write <= writedata[CMD_WRITE];
                op_read  <= writedata[CMD_READ] && !writedata[CMD_WRITE];
                op_stop  <= writedata[CMD_STOP];
                op_nack  <= writedata[CMD_NACK];
                nack     <= 1'b0;
            end else if (busy && tick) begin
                q <= q + 2'd1;
                // Sampling on entry to Q2 gives SDA a full quarter of SCL-high to settle through the synchroniser
                if (q == 2'd1) begin
                    if (state == ST_RD_BIT)           rx_shift  <= {rx_shift[6:0], sda_sync[1]};
                    if (state == ST_ACK && op_write)  nack_pend <= sda_sync[1];
                end
                if (q == 2'd3) begin
                    case (state)
                        ST_START:  bus_held <= 1'b1;
                        ST_STOP:   bus_held <= 1'b0;
                        ST_WR_BIT: begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        ST_RD_BIT: bit_cnt <= bit_cnt + 3'd1;
                        default: ;
                    endcase
                    if (next_state == ST_IDLE) begin
                        if (op_write) nack    <= nack_pend;
                        if (op_read)  rx_byte <= rx_shift;
                    end
                end
            end

            if (chipselect) begin
                case (address)
                    ADDR_DATA:   readdata <= {24'b0, rx_byte};
                    ADDR_STATUS: readdata <= {29'b0, bus_held, nack, busy};
                    default:     readdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eep_i2c_master.sv
// tb/tb_eep_i2c_master.sv - directed bench for eep_i2c_master with a scripted slave
module tb_eep_i2c_master;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    wire         scl, sda;

    int checks = 0;
    int failures = 0;

    logic       slave_low = 1'b0;
    logic [8:0] pattern = 9'h1FF;
    int         rise_total = 0;
    int         rise_base = 0;
    int         start_total = 0;
    int         stop_total = 0;
    logic       bit_log [64];
    event       arm_ev;

    pullup (scl);
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    eep_i2c_master #(.CLK_DIV(C)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl        (scl),
        .sda        (sda)
    );

    always #5 clk = ~clk;

    always @(posedge scl) begin
        bit_log[rise_total & 63] = sda;
        rise_total = rise_total + 1;
    end

    always @(negedge sda) if (scl === 1'b1) start_total = start_total + 1;
    always @(posedge sda) if (scl === 1'b1) stop_total = stop_total + 1;

    // Slave changes SDA only while SCL is low; slot index counts SCL rises since arming
    always begin
        @(negedge scl or arm_ev);
        begin
            int idx;
            idx = rise_total - rise_base;
            if (scl !== 1'b0 || idx < 0 || idx > 8) slave_low = 1'b0;
            else slave_low = !pattern[8 - idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic arm(input logic [8:0] p);
        pattern   = p;
        rise_base = rise_total;
        -> arm_ev;
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        address = 2'd2; chipselect = 1'b1; write_n = 1'b1;
        cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (readdata[0]) cycles++;
            else break;
        end
        chipselect = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] cmd, output int cycles);
        bus_write(2'd1, {24'b0, cmd});
        wait_idle(cycles);
    endtask

    function automatic logic [7:0] logged_byte(input int base);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], bit_log[(base + i) & 63]};
        return b;
    endfunction

    initial begin
        logic [31:0] rd;
        int cyc, s0, p0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", {31'b0, scl}, 32'd1);
        check("rst_sda", {31'b0, sda}, 32'd1);
        check("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        bus_read(2'd2, rd); check("rst_status", rd, 32'd0);
        bus_read(2'd0, rd); check("rst_data", rd, 32'd0);

        // START + WRITE 0xA0 with slave ACK
        bus_write(2'd0, 32'hA0);
        arm(9'b1_1111_1110);
        s0 = start_total;
        run_cmd(8'h03, cyc);
        check("sw_busy_len", cyc, 40 * C);
        check("sw_byte", logged_byte(rise_base), 32'hA0);
        check("sw_ack_slot", {31'b0, bit_log[(rise_base + 8) & 63]}, 32'd0);
        check("sw_rises", rise_total - rise_base, 9);
        check("sw_start", start_total - s0, 1);
        check("sw_scl_held", {31'b0, scl}, 32'd0);
        bus_read(2'd2, rd); check("sw_status", rd, 32'h4);

        // READ + NACK + STOP, slave returns 0x5A
        arm({8'h5A, 1'b1});
        p0 = stop_total;
        run_cmd(8'h1C, cyc);
        check("rd_busy_len", cyc, 40 * C);
        bus_read(2'd0, rd); check("rd_data", rd, 32'h5A);
        check("rd_master_nack", {31'b0, bit_log[(rise_base + 8) & 63]}, 32'd1);
        check("rd_rises", rise_total - rise_base, 10);
        check("rd_stop", stop_total - p0, 1);
        bus_read(2'd2, rd); check("rd_status", rd, 32'h0);
        check("rd_bus_free", {30'b0, scl, sda}, 32'h3);

        // START + WRITE 0x50 + STOP, slave NACKs
        bus_write(2'd0, 32'h50);
        arm(9'h1FF);
        s0 = start_total; p0 = stop_total;
        run_cmd(8'h0B, cyc);
        check("nk_busy_len", cyc, 44 * C);
        check("nk_byte", logged_byte(rise_base), 32'h50);
        check("nk_start_stop", {(start_total - s0), (stop_total - p0)}, {32'd1, 32'd1});
        bus_read(2'd2, rd); check("nk_status", rd, 32'h2);
        arm(9'h1FF);
        run_cmd(8'h01, cyc);
        check("nk_start_len", cyc, 4 * C);
        bus_read(2'd2, rd); check("nk_cleared", rd, 32'h4);
        run_cmd(8'h08, cyc);
        check("nk_stop_len", cyc, 4 * C);
        bus_read(2'd2, rd); check("nk_stop_status", rd, 32'h0);

        // NACK bit alone launches nothing
        bus_write(2'd1, 32'h10);
        repeat (3) @(posedge clk);
        #1;
        bus_read(2'd2, rd); check("nackonly_status", rd, 32'h0);

        // Writes during busy are ignored
        bus_write(2'd0, 32'h3C);
        arm(9'b1_1111_1110);
        bus_write(2'd1, 32'h0B);
        repeat (40) @(posedge clk);
        #1;
        bus_write(2'd0, 32'hFF);
        bus_write(2'd1, 32'h02);
        wait_idle(cyc);
        check("lk_timeout", {31'b0, cyc < 2000}, 32'd1);
        check("lk_byte", logged_byte(rise_base), 32'h3C);
        repeat (200) @(posedge clk);
        #1;
        check("lk_rises", rise_total - rise_base, 10);
        bus_read(2'd2, rd); check("lk_status", rd, 32'h0);

        // Reset during bit 4 of 0xA0 (master driving SDA low, SCL low in Q0)
        bus_write(2'd0, 32'hA0);
        arm(9'h1FF);
        bus_write(2'd1, 32'h03);
        repeat (81) @(posedge clk);
        #1;
        check("mr_pre_pads", {30'b0, scl, sda}, 32'h0);
        reset_n = 1'b0;
        #1;
        check("mr_pads_released", {30'b0, scl, sda}, 32'h3);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(2'd2, rd); check("mr_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
